pwm_output_scheduler: RTL
=========================

# pwm_output_scheduler

Owns the shared RGB LED pins and the servo pin, and decides which PWM generator drives them. Generators covered: linear, sine, rainbow and servo. Switch requests are synchronised, debounced and priority-encoded into a mode. Mode changes are applied only on PWM period boundaries, with a blanking interval between modes, so that no runt pulse or stuck servo level reaches the pins. It sits between the PWM generator instances and the top-level pins.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required to accept a switch change. Legal range is ≥1.
- BLANK_PERIODS, default 1: number of full PWM periods the outputs are forced low between modes. Legal range is 0–255.

Ports:
- clk  in  1  system clock. The block uses one clock only.
- rst_n  in  1  reset, asynchronous, active-low.
- sw  in  4  raw mode switches. Asynchronous to clk.
- period_tick  in  1  single-cycle strobe at each PWM period start, from the shared PWM counter.
- linear_in  in  1  linear generator PWM.
- sin_in  in  1  sine generator PWM.
- r_in, g_in, b_in  in  1 each  rainbow generator PWMs.
- servo_in  in  1  servo generator PWM.
- rgb  out  3  LED drive, with bit 0 = red, 1 = green, 2 = blue. Registered.
- servo_out  out  1  servo drive. Registered.
- mode  out  3  active mode: 0 OFF, 1 LINEAR, 2 SINE, 3 RAINBOW, 4 SERVO.
- switching  out  1  high while a mode change is pending or blanking.

## Operation

Input conditioning:
- sw passes through a 2-flop synchroniser, giving sw_s.
- A fixed-priority encode of sw_s produces cand:
  - sw_s[0] gives LINEAR.
  - Otherwise sw_s[1] gives SINE.
  - Otherwise sw_s[2] gives RAINBOW.
  - Otherwise sw_s[3] gives SERVO.
  - Otherwise cand is OFF.
- Debounce counter behaviour:
  - It clears whenever cand differs from the previous cycle's cand.
  - Otherwise it increments, saturating at DEBOUNCE_CYCLES-1.
  - req_mode is loaded with cand on the cycle the counter is at DEBOUNCE_CYCLES-1.

FSM states (reset state RUN):
- RUN: outputs follow mode. If req_mode ≠ mode, go to PEND.
- PEND: outputs still follow mode.
  - If req_mode returns to equal mode, go to RUN with no blanking.
  - Else, on period_tick with BLANK_PERIODS=0: mode ← req_mode and go to RUN.
  - Else, on period_tick: clear blank_cnt and go to BLANK.
- BLANK: rgb=0 and servo_out=0. Each period_tick increments blank_cnt (8 bits).
  - When a tick makes blank_cnt equal BLANK_PERIODS: mode ← req_mode (its value at that cycle) and go to RUN.
  - A req_mode change during BLANK does not restart blanking. The exit loads the latest req_mode, even if it equals the old mode.

Output mux, registered and applied one cycle after the state/mode decision:
- OFF: rgb=000.
- LINEAR: rgb={0,0,linear_in}.
- SINE: rgb={sin_in,0,0}.
- RAINBOW: rgb={b_in,g_in,r_in}.
- SERVO: rgb=000 and servo_out=servo_in.
- servo_out=0 in every state/mode other than RUN/PEND with mode=SERVO. The pin never holds a stale level.

Other rules:
- switching = (state ≠ RUN).
- Reset values: rgb=000, servo_out=0, mode=0 (OFF), switching=0, req_mode=OFF, sync flops=0, counters=0, state RUN.

## Timing

Latencies:
- sw edge to cand: 2–3 cycles (synchroniser).
- cand to req_mode: DEBOUNCE_CYCLES cycles of stability.
- req_mode ≠ mode to PEND (switching=1): 1 cycle.
- period_tick in PEND to BLANK: registered on that edge. rgb/servo_out go low 1 cycle later.

Blanking:
- The BLANK exit tick loads mode on that edge.
- New-mode outputs appear on the following edge.
- Total blanked time is BLANK_PERIODS full periods, give or take 1 cycle of register delay.

Boundary conditions:
- period_tick arriving on the same cycle PEND is entered is not sampled. Only ticks seen while in PEND count.
- A switch bounce shorter than DEBOUNCE_CYCLES never changes req_mode.
- Asserting rst_n low mid-BLANK or mid-PEND forces the reset values immediately (async). After release, the block resumes in RUN/OFF and re-debounces the switches.
- Multiple switches on: priority encode applies, so sw=1010 gives SINE.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, BLANK_PERIODS=1, period_tick every 16 cycles.

- Reset: hold rst_n=0 with sw=0001 and all PWM inputs=1. Required: rgb=000, servo_out=0, mode=0, switching=0. After release, mode becomes 1 only after ≥6 cycles.
- Debounce: toggle sw[1] high for 3 cycles, then low. Required: req_mode and mode stay 0 and switching stays 0. Then hold sw[1] high. Required: switching=1 after debounce, mode=2 after the second subsequent period_tick.
- Blanking: from RAINBOW (sw=0100), switch to LINEAR (sw=0001) with r_in=g_in=b_in=linear_in=1. Required: rgb=111 until the first period_tick in PEND, then rgb=000 for 16 cycles, then rgb=001.
- Servo release: in SERVO with servo_in=1, set sw=0000. Required: servo_out=1 until the PEND tick, 0 from the next cycle onward, and mode=0 after blanking.
- Cancel: in SINE, request RAINBOW, then return to SINE before any period_tick. Required: switching pulses and clears, rgb never blanks, mode stays 2.
- Async reset mid-BLANK: assert rst_n=0 for 1 cycle. Required: outputs 000/0, mode=0 and state RUN immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pwm_output_scheduler.sv
// rtl/pwm_output_scheduler.sv - switch-driven PWM source selector with period-aligned blanking
module pwm_output_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLANK_PERIODS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       period_tick,
    input  logic       linear_in,
    input  logic       sin_in,
    input  logic       r_in,
    input  logic       g_in,
    input  logic       b_in,
    input  logic       servo_in,
    output logic [2:0] rgb,
    output logic       servo_out,
    output logic [2:0] mode,
    output logic       switching
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] BLANK_N = 8'(BLANK_PERIODS);

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_LINEAR  = 3'd1;
    localparam logic [2:0] MODE_SINE    = 3'd2;
    localparam logic [2:0] MODE_RAINBOW = 3'd3;
    localparam logic [2:0] MODE_SERVO   = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       sw_m;
    logic [3:0]       sw_s;
    logic [2:0]       cand;
    logic [2:0]       cand_q;
    logic [2:0]       req_mode;
    logic [CNT_W-1:0] deb_cnt;
    logic [7:0]       blank_cnt;
    logic [7:0]       blank_nxt;

    assign blank_nxt = blank_cnt + 8'd1;
    assign switching = (state != ST_RUN);

    // Two-flop synchroniser for the raw asynchronous switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m <= 4'b0000;
            sw_s <= 4'b0000;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    // Fixed-priority encode: lowest-numbered active switch wins
    always_comb begin
        cand = MODE_OFF;
        if (sw_s[0])      cand = MODE_LINEAR;
        else if (sw_s[1]) cand = MODE_SINE;
        else if (sw_s[2]) cand = MODE_RAINBOW;
        else if (sw_s[3]) cand = MODE_SERVO;
    end

    // Debounce: any change of the candidate restarts the stability count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= MODE_OFF;
            deb_cnt  <= '0;
            req_mode <= MODE_OFF;
        end else begin
            cand_q <= cand;
            if (cand != cand_q) begin
                deb_cnt <= '0;
            end else if (deb_cnt != CNT_MAX) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            // Only accept a candidate that is still unchanged on the saturated cycle,
            // so a change landing on that cycle cannot slip through undebounced
            if (deb_cnt == CNT_MAX && cand == cand_q) begin
                req_mode <= cand;
            end
        end
    end

    // Mode switch FSM: changes wait for a period boundary, then blank for whole periods
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            mode      <= MODE_OFF;
            blank_cnt <= 8'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (req_mode != mode) begin
                        state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (req_mode == mode) begin
                        state <= ST_RUN;
                    end else if (period_tick) begin
                        if (BLANK_N == 8'd0) begin
                            mode  <= req_mode;
                            state <= ST_RUN;
                        end else begin
                            blank_cnt <= 8'd0;
                            state     <= ST_BLANK;
                        end
                    end
                end
                ST_BLANK: begin
                    // Blanking always runs to completion; exit takes whatever is requested now
                    if (period_tick) begin
                        blank_cnt <= blank_nxt;
                        if (blank_nxt == BLANK_N) begin
                            mode  <= req_mode;
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Registered pin mux; servo pin is driven only while servo mode is live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb       <= 3'b000;
            servo_out <= 1'b0;
        end else begin
            rgb       <= 3'b000;
            servo_out <= 1'b0;
            if (state != ST_BLANK) begin
                case (mode)
                    MODE_LINEAR:  rgb <= {2'b00, linear_in};
                    MODE_SINE:    rgb <= {sin_in, 2'b00};
                    MODE_RAINBOW: rgb <= {b_in, g_in, r_in};
                    MODE_SERVO:   servo_out <= servo_in;
                    default:      rgb <= 3'b000;
                endcase
            end
        end
    end

endmodule
